// File: rtl/sensor_poll_scheduler.sv
// sensor_poll_scheduler
// Sweeps up to 32 sensors in ascending address order. Each enabled sensor
// gets a one-cycle request strobe, then the scheduler waits for its response
// and forwards the captured data together with the sensor address.
//
// Optional feature macro: SENSOR_POLL_TIMEOUT_EN
//   defined   : a WAIT timer flags sensors that stay silent for TIMEOUT_CYCLES
//               cycles in err_mask and moves on to the next sensor.
//   undefined : WAIT holds until rsp_valid or abort; err_mask is tied to 0.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active low
//   start      : begin one sweep (sampled only while idle)
//   abort      : cancel the current sweep, back to idle next cycle
//   enable     : per-sensor poll mask, snapshotted at start
//   rsp_valid  : addressed sensor presents rsp_data this cycle
//   rsp_data   : sensor response data
//   sel_addr   : sensor select address, held between requests
//   req        : one-cycle request strobe
//   busy       : high whenever a sweep is in progress
//   data_valid : one-cycle strobe qualifying data_out / data_addr
//   data_out   : captured response data
//   data_addr  : address of the sensor that produced data_out
//   err_mask   : sticky timeout flags for the current sweep
//   done       : one-cycle end-of-sweep strobe
module sensor_poll_scheduler #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int DW             = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [31:0]   enable,
    input  logic          rsp_valid,
    input  logic [DW-1:0] rsp_data,
    output logic [4:0]    sel_addr,
    output logic          req,
    output logic          busy,
    output logic          data_valid,
    output logic [DW-1:0] data_out,
    output logic [4:0]    data_addr,
    output logic [31:0]   err_mask,
    output logic          done
);

    // The timer is 16 bits wide, so the parameter must fit.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range
        $fatal(1, "TIMEOUT_CYCLES out of range 2..65535");
    end

    typedef enum logic [2:0] {IDLE, SCAN, REQ, WAIT, NEXT, DONE} state_t;

    state_t        state_reg, state_next;
    logic [4:0]    ptr_reg, ptr_next;
    logic [31:0]   mask_reg, mask_next;
    logic [4:0]    sel_addr_reg, sel_addr_next;
    logic          req_reg, req_next;
    logic          busy_reg, busy_next;
    logic          data_valid_reg, data_valid_next;
    logic [DW-1:0] data_out_reg, data_out_next;
    logic [4:0]    data_addr_reg, data_addr_next;
    logic          done_reg, done_next;
`ifdef SENSOR_POLL_TIMEOUT_EN
    logic [15:0]   timer_reg, timer_next;
    logic [31:0]   err_mask_reg, err_mask_next;
`endif

    always_comb begin
        state_next      = state_reg;
        ptr_next        = ptr_reg;
        mask_next       = mask_reg;
        sel_addr_next   = sel_addr_reg;
        req_next        = 1'b0;
        data_valid_next = 1'b0;
        data_out_next   = data_out_reg;
        data_addr_next  = data_addr_reg;
        done_next       = 1'b0;
`ifdef SENSOR_POLL_TIMEOUT_EN
        timer_next      = timer_reg;
        err_mask_next   = err_mask_reg;
`endif
        // Abort wins over every other transition and suppresses all strobes
        // and captures that the current state would otherwise produce.
        if (abort && state_reg != IDLE) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mask_next  = enable;
                        ptr_next   = 5'd0;
`ifdef SENSOR_POLL_TIMEOUT_EN
                        err_mask_next = 32'd0;
`endif
                        state_next = SCAN;
                    end
                end
                SCAN: begin
                    if (mask_reg[ptr_reg]) begin
                        state_next = REQ;
                    end else if (ptr_reg == 5'd31) begin
                        state_next = DONE;
                    end else begin
                        ptr_next = ptr_reg + 5'd1;
                    end
                end
                REQ: begin
                    sel_addr_next = ptr_reg;
                    req_next      = 1'b1;
`ifdef SENSOR_POLL_TIMEOUT_EN
                    timer_next    = 16'd0;
`endif
                    state_next    = WAIT;
                end
                WAIT: begin
                    // A response on the timeout cycle still counts as a response.
                    if (rsp_valid) begin
                        data_out_next   = rsp_data;
                        data_addr_next  = ptr_reg;
                        data_valid_next = 1'b1;
                        state_next      = NEXT;
                    end
`ifdef SENSOR_POLL_TIMEOUT_EN
                    else if (timer_reg == 16'(TIMEOUT_CYCLES - 1)) begin
                        err_mask_next[ptr_reg] = 1'b1;
                        state_next             = NEXT;
                    end else begin
                        timer_next = timer_reg + 16'd1;
                    end
`endif
                end
                NEXT: begin
                    // ptr stops at 31 so a sweep never wraps back to sensor 0.
                    if (ptr_reg == 5'd31) begin
                        state_next = DONE;
                    end else begin
                        ptr_next   = ptr_reg + 5'd1;
                        state_next = SCAN;
                    end
                end
                DONE: begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
        // Registered from the next state so busy tracks the state exactly.
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            ptr_reg        <= 5'd0;
            mask_reg       <= 32'd0;
            sel_addr_reg   <= 5'd0;
            req_reg        <= 1'b0;
            busy_reg       <= 1'b0;
            data_valid_reg <= 1'b0;
            data_out_reg   <= '0;
            data_addr_reg  <= 5'd0;
            done_reg       <= 1'b0;
`ifdef SENSOR_POLL_TIMEOUT_EN
            timer_reg      <= 16'd0;
            err_mask_reg   <= 32'd0;
`endif
        end else begin
            state_reg      <= state_next;
            ptr_reg        <= ptr_next;
            mask_reg       <= mask_next;
            sel_addr_reg   <= sel_addr_next;
            req_reg        <= req_next;
            busy_reg       <= busy_next;
            data_valid_reg <= data_valid_next;
            data_out_reg   <= data_out_next;
            data_addr_reg  <= data_addr_next;
            done_reg       <= done_next;
`ifdef SENSOR_POLL_TIMEOUT_EN
            timer_reg      <= timer_next;
            err_mask_reg   <= err_mask_next;
`endif
        end
    end

    assign sel_addr   = sel_addr_reg;
    assign req        = req_reg;
    assign busy       = busy_reg;
    assign data_valid = data_valid_reg;
    assign data_out   = data_out_reg;
    assign data_addr  = data_addr_reg;
    assign done       = done_reg;
`ifdef SENSOR_POLL_TIMEOUT_EN
    assign err_mask   = err_mask_reg;
`else
    assign err_mask   = 32'd0;
`endif

endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// Testbench for sensor_poll_scheduler: directed steps plus randomized sweeps
// checked against a transaction-level model of one sweep.
module tb_sensor_poll_scheduler;
    localparam int TO = 4;
    localparam int DW = 8;
`ifdef SENSOR_POLL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk, rst, start, abort, rsp_valid;
    logic [31:0]   enable;
    logic [DW-1:0] rsp_data;
    logic [4:0]    sel_addr, data_addr;
    logic          req, busy, data_valid, done;
    logic [DW-1:0] data_out;
    logic [31:0]   err_mask;

    sensor_poll_scheduler #(.TIMEOUT_CYCLES(TO), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .enable(enable),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .sel_addr(sel_addr),
        .req(req), .busy(busy), .data_valid(data_valid), .data_out(data_out),
        .data_addr(data_addr), .err_mask(err_mask), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Sensor behaviour per address: response delay (cycles after req is seen)
    int          delay_arr [32];
    logic [7:0]  data_arr  [32];

    // Observed transactions
    int          req_q [$];
    logic [12:0] dv_q  [$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (req)        req_q.push_back(int'(sel_addr));
            if (data_valid) dv_q.push_back({data_addr, data_out});
            if (done)       done_cnt++;
        end
    end

    // Responder: answers the addressed sensor after its configured delay.
    int         pend_cnt = 0;
    bit         pend = 1'b0;
    logic [4:0] pend_addr = 5'd0;
    initial begin
        rsp_valid = 1'b0;
        rsp_data  = '0;
    end
    always @(negedge clk) begin
        rsp_valid = 1'b0;
        if (!rst) begin
            pend = 1'b0;
        end else begin
            if (req) begin
                pend      = 1'b1;
                pend_cnt  = delay_arr[sel_addr];
                pend_addr = sel_addr;
            end
            if (pend) begin
                if (pend_cnt == 0) begin
                    rsp_valid = 1'b1;
                    rsp_data  = data_arr[pend_addr];
                    pend      = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        req_q.delete();
        dv_q.delete();
        done_cnt = 0;
    endtask

    // Pulse start with mask m; afterwards scramble enable, which must not matter.
    task automatic do_start(input logic [31:0] m);
        @(negedge clk);
        enable = m;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        enable = $urandom;
        check("busy_after_start", busy, 1);
        check("err_cleared_at_start", err_mask, 0);
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (!done && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", done, 1);
    endtask

    // Model one full sweep and compare with what the monitor collected.
    task automatic run_sweep(input string name, input logic [31:0] m);
        int          exp_req [$];
        logic [12:0] exp_dv  [$];
        logic [31:0] exp_err;
        int          k;
        exp_err = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if (m[i]) begin
                exp_req.push_back(i);
                if (!TO_EN || delay_arr[i] <= TO - 1)
                    exp_dv.push_back({5'(i), data_arr[i]});
                else
                    exp_err[i] = 1'b1;
            end
        end
        clear_obs();
        do_start(m);
        wait_done(k);
        @(negedge clk);
        @(negedge clk);
        check({name, ":req_count"}, req_q.size(), exp_req.size());
        for (int i = 0; i < exp_req.size(); i++)
            check($sformatf("%s:req_addr[%0d]", name, i),
                  (i < req_q.size()) ? req_q[i] : -1, exp_req[i]);
        check({name, ":dv_count"}, dv_q.size(), exp_dv.size());
        for (int i = 0; i < exp_dv.size(); i++)
            check($sformatf("%s:dv[%0d]", name, i),
                  (i < dv_q.size()) ? dv_q[i] : 13'h1fff, exp_dv[i]);
        check({name, ":err_mask"}, err_mask, exp_err);
        check({name, ":done_count"}, done_cnt, 1);
        check({name, ":busy_idle"}, busy, 0);
        $display("sweep %s mask=%08h reqs=%0d data=%0d err=%08h cycles=%0d",
                 name, m, req_q.size(), dv_q.size(), err_mask, k);
    endtask

    initial begin
        int k;
        rst = 1'b0; start = 1'b0; abort = 1'b0; enable = 32'd0;
        for (int i = 0; i < 32; i++) begin
            delay_arr[i] = 1;
            data_arr[i]  = 8'h00;
        end
        #1;
        check("rst:busy", busy, 0);
        check("rst:req", req, 0);
        check("rst:sel_addr", sel_addr, 0);
        check("rst:data_valid", data_valid, 0);
        check("rst:data_out", data_out, 0);
        check("rst:data_addr", data_addr, 0);
        check("rst:err_mask", err_mask, 0);
        check("rst:done", done, 0);
        $display("reset state checked");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Empty mask: done exactly 33 cycles after the start edge, no req.
        clear_obs();
        do_start(32'h0000_0000);
        wait_done(k);
        check("empty:done_latency", k, 33);
        @(negedge clk);
        check("empty:req_count", req_q.size(), 0);
        check("empty:err_mask", err_mask, 0);
        $display("sweep empty done_latency=%0d", k);

        // Sensors 0 and 31, response three cycles after each req.
        delay_arr[0] = 3;  data_arr[0]  = 8'hA5;
        delay_arr[31] = 3; data_arr[31] = 8'h5A;
        run_sweep("ends", 32'h8000_0001);

        // Response landing on the timeout cycle counts as data.
        delay_arr[4] = TO - 1; data_arr[4] = 8'h3C;
        run_sweep("rsp_on_timeout", 32'h0000_0010);

`ifdef SENSOR_POLL_TIMEOUT_EN
        // Silent sensor times out and is flagged.
        delay_arr[2] = 255;
        run_sweep("timeout", 32'h0000_0004);
        repeat (3) @(negedge clk);
        check("timeout:err_sticky", err_mask, 32'h0000_0004);
`endif

        // Randomized sweeps with random delays (some beyond the timeout).
        for (int s = 0; s < 5; s++) begin
            for (int i = 0; i < 32; i++) begin
                delay_arr[i] = $urandom_range(0, 5);
                data_arr[i]  = 8'($urandom);
            end
            run_sweep($sformatf("rand%0d", s), $urandom & $urandom);
        end

        // Abort while waiting on sensor 5.
        for (int i = 0; i < 32; i++) delay_arr[i] = 1;
        delay_arr[5] = 200;
        clear_obs();
        do_start(32'hFFFF_FFFF);
        k = 0;
        while (!(req && sel_addr == 5'd5) && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("abort:reached_s5", (req && sel_addr == 5'd5), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort:busy", busy, 0);
        check("abort:data_valid", data_valid, 0);
        check("abort:done", done, 0);
        repeat (10) @(negedge clk);
        check("abort:no_done", done_cnt, 0);
        check("abort:req_count", req_q.size(), 6);
        check("abort:dv_count", dv_q.size(), 5);
        $display("abort at sensor 5 reqs=%0d data=%0d", req_q.size(), dv_q.size());
        for (int i = 0; i < 32; i++) begin
            delay_arr[i] = $urandom_range(0, 3);
            data_arr[i]  = 8'($urandom);
        end
        run_sweep("restart", 32'hFFFF_FFFF);

        // Reset while waiting: outputs clear at once, no done afterwards.
        delay_arr[4] = 200;
        clear_obs();
        do_start(32'h0000_0010);
        k = 0;
        while (!req && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("rstwait:req_seen", req, 1);
        rst = 1'b0;
        #1;
        check("rstwait:busy", busy, 0);
        check("rstwait:req", req, 0);
        check("rstwait:sel_addr", sel_addr, 0);
        check("rstwait:data_out", data_out, 0);
        check("rstwait:data_addr", data_addr, 0);
        check("rstwait:err_mask", err_mask, 0);
        @(negedge clk);
        rst = 1'b1;
        done_cnt = 0;
        repeat (40) @(negedge clk);
        check("rstwait:no_done", done_cnt, 0);
        check("rstwait:idle", busy, 0);
        $display("reset during wait checked");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sensor_poll_scheduler.md
SENSOR_POLL_SCHEDULER -- requirements
Module: sensor_poll_scheduler

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1000, giving the WAIT cycles before a sensor is declared unresponsive (range 2..65535).
REQ-002 The block SHALL have parameter DW, default 8, giving the sensor response data width.
REQ-003 clk  in  1  clock; all state changes on the rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  begin one polling sweep; sampled only in IDLE.
REQ-006 abort  in  1  synchronous sweep cancel.
REQ-007 enable  in  32  per-sensor poll mask; bit i set means sensor i is polled.
REQ-008 rsp_valid  in  1  addressed sensor returns data this cycle.
REQ-009 rsp_data  in  DW  sensor response data.
REQ-010 sel_addr  out  5  address of the sensor being polled, driving the sensor select mux.
REQ-011 req  out  1  one-cycle request strobe to the addressed sensor.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 data_valid  out  1  one-cycle strobe qualifying data_out and data_addr.
REQ-014 data_out  out  DW  captured response; data_addr  out  5  its sensor address.
REQ-015 err_mask  out  32  sticky per-sweep timeout flags, bit i for sensor i.
REQ-016 done  out  1  one-cycle end-of-sweep strobe.

Function
REQ-017 The FSM SHALL have states IDLE, SCAN, REQ, WAIT, NEXT, DONE; all outputs SHALL be registered.
REQ-018 IDLE: start=1 SHALL snapshot enable into mask_q, set ptr=0, clear err_mask, and enter SCAN; start outside IDLE SHALL be ignored.
REQ-019 SCAN (one index per cycle): mask_q[ptr]=1 -> REQ; else ptr=31 -> DONE; else ptr+1, stay in SCAN.
REQ-020 REQ: sel_addr=ptr and req=1 for exactly one cycle, timer cleared -> WAIT; sel_addr SHALL hold its value until the next REQ.
REQ-021 WAIT: rsp_valid=1 -> data_out=rsp_data, data_addr=ptr, data_valid=1 for one cycle -> NEXT.
REQ-022 WAIT: timer reaching TIMEOUT_CYCLES-1 without rsp_valid -> err_mask[ptr]=1, no data_valid -> NEXT.
REQ-023 rsp_valid and timeout in the same cycle SHALL be treated as a response (no error flag).
REQ-024 rsp_valid outside WAIT SHALL be ignored.
REQ-025 NEXT: ptr=31 -> DONE; else ptr+1 -> SCAN; ptr SHALL never wrap within a sweep.
REQ-026 DONE: done=1 for one cycle -> IDLE; err_mask SHALL hold until the next start.
REQ-027 abort=1 in any non-IDLE state SHALL return to IDLE next cycle with no done, req or data_valid; abort has priority over all transitions.
REQ-028 Changes to enable during a sweep SHALL have no effect until the next start.
REQ-029 Empty mask: done SHALL assert 33 cycles after the start-sampling edge with no req issued.

Reset
REQ-030 rst low SHALL force IDLE with ptr=0, sel_addr=0, req=0, busy=0, data_valid=0, data_out=0, data_addr=0, err_mask=0, done=0, mask_q=0.
REQ-031 Reset mid-sweep SHALL discard the sweep; no done SHALL follow reset release.

Configuration
REQ-032 Macro SENSOR_POLL_TIMEOUT_EN defined: the timer and REQ-022/023 SHALL be compiled in.
REQ-033 Macro SENSOR_POLL_TIMEOUT_EN undefined: no timer SHALL be compiled in, WAIT SHALL wait indefinitely for rsp_valid or abort, and err_mask SHALL be tied to 0.

Verification
REQ-034 enable=0x00000000, start pulse -> no req, done 33 cycles after start, err_mask=0.
REQ-035 enable=0x80000001, rsp_valid 3 cycles after each req with rsp_data=0xA5 then 0x5A -> req at sel_addr 0 then 31, data_valid with (0,0xA5) then (31,0x5A), done once.
REQ-036 TIMEOUT_CYCLES=4, enable=0x00000004, no rsp_valid -> err_mask=0x00000004, no data_valid, done asserted (macro defined).
REQ-037 enable=0x00000010, rsp_valid on the timeout cycle -> data_valid with data_addr=4, err_mask=0.
REQ-038 enable=0xFFFFFFFF, abort during WAIT on sensor 5 -> IDLE next cycle, busy=0, no done; a new start restarts at sensor 0.
REQ-039 rst asserted during WAIT -> all outputs at reset values immediately; no done after release.
